// File: rtl/oam_dma.sv
// OAM DMA engine: copies OAM_BYTES bytes from page {src_eff,8'h00} into OAM as a bus master.
// Each byte is one READ cycle followed by one WRITE cycle that forwards m_rdata.
module oam_dma #(
  parameter int                 ADDR_W       = 16,
  parameter int                 DATA_W       = 8,
  parameter logic [ADDR_W-1:0]  DMA_REG_ADDR = 16'hFF46,
  parameter logic [ADDR_W-1:0]  OAM_BASE     = 16'hFE00,
  parameter int                 OAM_BYTES    = 160
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              reg_hit,
  output logic [DATA_W-1:0] reg_rdata,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_rd,
  output logic              m_wr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy,
  output logic              cpu_block,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam logic [7:0] LAST_IDX = 8'(OAM_BYTES - 1);

  logic [1:0]        state;
  logic [DATA_W-1:0] dma_reg;
  logic [7:0]        idx;
  logic [DATA_W-1:0] src_eff;
  logic              trigger;

  assign trigger   = cpu_wr && (cpu_addr == DMA_REG_ADDR);
  assign reg_hit   = cpu_rd && (cpu_addr == DMA_REG_ADDR);
  assign reg_rdata = reg_hit ? dma_reg : '0;

  // Sources in echo RAM (E0..FF) are folded back onto C0..DF.
  assign src_eff = (dma_reg >= DATA_W'(8'hE0)) ? dma_reg - DATA_W'(8'h20) : dma_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      dma_reg <= '0;
      idx     <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      // A register write restarts the copy from any state, dropping the byte in flight.
      if (trigger) begin
        dma_reg <= cpu_wdata;
        idx     <= '0;
        state   <= S_REQ;
      end else begin
        case (state)
          S_REQ:   if (bus_gnt) state <= S_READ;
          S_READ:  state <= S_WRITE;
          S_WRITE: begin
            if (idx == LAST_IDX) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end else begin
              idx   <= idx + 8'd1;
              state <= S_READ;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Grant is only sampled in REQ: the arbiter holds it while bus_req stays high.
  always_comb begin
    bus_req = 1'b0;
    m_rd    = 1'b0;
    m_wr    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    case (state)
      S_REQ:   bus_req = 1'b1;
      S_READ: begin
        bus_req = 1'b1;
        m_rd    = 1'b1;
        m_addr  = ADDR_W'({src_eff, idx});
      end
      S_WRITE: begin
        bus_req = 1'b1;
        m_wr    = 1'b1;
        m_addr  = OAM_BASE + ADDR_W'(idx);
        m_wdata = m_rdata;
      end
      default: ;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign cpu_block = busy;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: register-read vector table, fixed corner sequences and random
// transfers, all checked against a transfer-level model of the expected bus traffic.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_wr = 1'b0, cpu_rd = 1'b0;
  logic [15:0] cpu_addr = 16'h0;
  logic [7:0]  cpu_wdata = 8'h0;
  logic        reg_hit;
  logic [7:0]  reg_rdata;
  logic        bus_req, bus_gnt;
  logic [15:0] m_addr;
  logic        m_rd, m_wr;
  logic [7:0]  m_wdata;
  logic [7:0]  m_rdata = 8'h0;
  logic        busy, cpu_block, done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  oam_dma dut (
    .clk(clk), .reset(rst),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .reg_hit(reg_hit), .reg_rdata(reg_rdata),
    .bus_req(bus_req), .bus_gnt(bus_gnt),
    .m_addr(m_addr), .m_rd(m_rd), .m_wr(m_wr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy), .cpu_block(cpu_block), .done(done)
  );

  // Memory model: read data appears the cycle after m_rd.
  logic [7:0] mem [0:65535];
  always @(posedge clk) if (m_rd) m_rdata <= mem[m_addr];

  // Arbiter model: grant after gnt_delay cycles of request, held while requested.
  int gnt_delay = 0;
  int req_cnt;
  always @(posedge clk or posedge rst)
    if (rst) req_cnt <= 0;
    else     req_cnt <= bus_req ? req_cnt + 1 : 0;
  assign bus_gnt = bus_req && (req_cnt >= gnt_delay);

  // Monitor: logs bus traffic since the last DMA-register write.
  int cyc = 0, trig_cyc = 0, busy_cnt = 0, wait_cnt = 0, viol = 0;
  logic [15:0] rd_a[$], wr_a[$];
  logic [7:0]  wr_d[$];
  int          rd_c[$], wr_c[$], done_c[$];

  always @(negedge clk) begin
    cyc++;
    if (m_rd && m_wr) viol++;
    if (cpu_block !== busy) viol++;
    if (!busy && (bus_req || m_rd || m_wr)) viol++;
    if (cpu_wr && cpu_addr == 16'hFF46) begin
      trig_cyc = cyc;
      rd_a.delete(); rd_c.delete(); wr_a.delete(); wr_d.delete(); wr_c.delete(); done_c.delete();
      busy_cnt = 0; wait_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (bus_req && !bus_gnt) wait_cnt++;
      if (m_rd) begin rd_a.push_back(m_addr); rd_c.push_back(cyc); end
      if (m_wr) begin wr_a.push_back(m_addr); wr_d.push_back(m_wdata); wr_c.push_back(cyc); end
      if (done) done_c.push_back(cyc);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic dma_write(input logic [7:0] v);
    @(posedge clk); #1;
    cpu_wr = 1'b1; cpu_addr = 16'hFF46; cpu_wdata = v;
    @(posedge clk); #1;
    cpu_wr = 1'b0; cpu_addr = 16'h0;
  endtask

  task automatic readback(input string nm, input logic [7:0] exp);
    @(posedge clk); #1;
    cpu_rd = 1'b1; cpu_addr = 16'hFF46;
    #1;
    chk({nm, "_hit"}, reg_hit, 1'b1);
    chk({nm, "_rdata"}, reg_rdata, exp);
    cpu_rd = 1'b0; cpu_addr = 16'h0;
  endtask

  task automatic wait_done(input string nm);
    bit ok = 0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      if (done_c.size() > 0 && !busy) begin ok = 1; break; end
    end
    if (!ok) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic wait_writes(input int n);
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      if (wr_a.size() >= n) return;
    end
    chk("wait_writes_timeout", wr_a.size(), n);
  endtask

  // Transfer model: 160 reads of page src_eff, each forwarded to OAM the next cycle.
  task automatic check_xfer(input string nm, input logic [7:0] v, input int delay);
    logic [7:0]  se;
    logic [15:0] sa;
    int bad_rd = 0, bad_wr = 0;
    se = (v >= 8'hE0) ? v - 8'h20 : v;
    chk({nm, "_nrd"}, rd_a.size(), 160);
    chk({nm, "_nwr"}, wr_a.size(), 160);
    for (int i = 0; i < 160 && i < rd_a.size() && i < wr_a.size(); i++) begin
      sa = {se, 8'(i)};
      if (rd_a[i] !== sa) bad_rd++;
      if (wr_a[i] !== 16'hFE00 + 16'(i) || wr_d[i] !== mem[sa] || wr_c[i] != rd_c[i] + 1) bad_wr++;
    end
    chk({nm, "_rd_addrs"}, bad_rd, 0);
    chk({nm, "_writes"}, bad_wr, 0);
    if (rd_c.size() > 0) chk({nm, "_first_rd_cyc"}, rd_c[0], trig_cyc + 2 + delay);
    chk({nm, "_gnt_wait"}, wait_cnt, delay);
    chk({nm, "_busy_cycles"}, busy_cnt, 321 + delay);
    chk({nm, "_done_count"}, done_c.size(), 1);
    if (done_c.size() > 0 && wr_c.size() > 0)
      chk({nm, "_done_cyc"}, done_c[0], wr_c[wr_c.size() - 1] + 1);
    readback({nm, "_reg"}, v);
  endtask

  typedef struct {
    logic        rd;
    logic [15:0] addr;
    logic        exp_hit;
    logic [7:0]  exp_rdata;
  } vec_t;

  initial begin
    vec_t vecs[4];
    int   saved;
    logic [7:0] rv;
    int   rd;

    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);

    vecs[0] = '{1'b1, 16'hFF46, 1'b1, 8'h00};
    vecs[1] = '{1'b1, 16'hFF47, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 16'hFF46, 1'b0, 8'h00};
    vecs[3] = '{1'b1, 16'h0F46, 1'b0, 8'h00};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {bus_req, m_rd, m_wr, busy, cpu_block, done, m_addr, m_wdata}, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_outputs", {bus_req, m_rd, m_wr, busy, cpu_block, done, m_addr, m_wdata}, 0);

    foreach (vecs[i]) begin
      cpu_rd = vecs[i].rd; cpu_addr = vecs[i].addr;
      #1;
      chk($sformatf("vec%0d_hit", i), reg_hit, vecs[i].exp_hit);
      chk($sformatf("vec%0d_rdata", i), reg_rdata, vecs[i].exp_rdata);
      @(posedge clk); #1;
    end
    cpu_rd = 1'b0; cpu_addr = 16'h0;

    // Immediate grant.
    gnt_delay = 0;
    dma_write(8'hC1);
    wait_done("c1");
    check_xfer("c1", 8'hC1, 0);

    // Echo-RAM source with a late grant.
    gnt_delay = 5;
    dma_write(8'hE3);
    wait_done("e3");
    check_xfer("e3", 8'hE3, 5);

    // Restart mid-transfer with a new source.
    gnt_delay = 0;
    dma_write(8'h80);
    wait_writes(40);
    chk("restart_no_early_done", done_c.size(), 0);
    dma_write(8'h90);
    wait_done("r90");
    check_xfer("r90", 8'h90, 0);

    // Asynchronous reset in the middle of a transfer.
    dma_write(8'h55);
    wait_writes(77);
    saved = wr_a.size();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_drop", {busy, bus_req, m_rd, m_wr, cpu_block}, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    chk("no_writes_after_rst", wr_a.size(), saved);
    chk("no_done_after_rst", done_c.size(), 0);
    readback("rst_reg", 8'h00);

    // Random sources and grant latencies.
    for (int t = 0; t < 4; t++) begin
      rv = 8'($urandom);
      rd = $urandom_range(0, 7);
      gnt_delay = rd;
      dma_write(rv);
      wait_done($sformatf("rnd%0d", t));
      check_xfer($sformatf("rnd%0d", t), rv, rd);
    end

    chk("invariants", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
